// File: rtl/ttl_sync_pkg.sv
// Shared conventions for the clock-enable based TTL primitives (74, 74112, 138).
// Edge-detector initial value, override priority and 138 decoder encoding.
package ttl_sync_pkg;

    localparam logic CEN_INIT = 1'b0;

    typedef enum logic [1:0] {
        OVR_NONE = 2'd0,
        OVR_CLR  = 2'd1,
        OVR_SET  = 2'd2
    } ovr_e;

    // Clear always beats preset; active-low parts invert their pins before calling this.
    function automatic ovr_e ovr_select(input logic clr, input logic set);
        if (clr)
            return OVR_CLR;
        else if (set)
            return OVR_SET;
        else
            return OVR_NONE;
    endfunction

    // Active-low one-hot output, all ones unless G1=1 and both G2 enables are low.
    function automatic logic [7:0] decode_138(input logic g1, input logic g2an,
                                              input logic g2bn, input logic [2:0] sel);
        logic [7:0] y;
        y = 8'hFF;
        if (g1 && !g2an && !g2bn)
            y[sel] = 1'b0;
        return y;
    endfunction

endpackage

// File: rtl/cen_rise_detect.sv
// Rising-edge detector for a level "TTL clock" sampled on the master clock.
// The delay flop tracks cen every cycle so overrides in the parent never defer an edge.
module cen_rise_detect
    import ttl_sync_pkg::*;
(
    input  logic clk,
    input  logic cen,
    output logic rise
);

    logic cen_dly_d;
    logic cen_dly_q = CEN_INIT;

    always_comb begin
        cen_dly_d = cen;
    end

    always_ff @(posedge clk) begin
        cen_dly_q <= cen_dly_d;
    end

    assign rise = cen & ~cen_dly_q;

endmodule

// File: rtl/dff_pseudo_async_clr_pre.sv
// 74-style D flop inside a single-clock design: captures din on a rising edge of cen,
// with clr/set applied synchronously in place of the TTL part's asynchronous pins.
module dff_pseudo_async_clr_pre
    import ttl_sync_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         set,
    input  logic         cen,
    input  logic [W-1:0] din,
    output logic [W-1:0] q,
    output logic [W-1:0] qn
);

    logic         cen_rise;
    logic [W-1:0] q_d;
    logic [W-1:0] q_q = '0;

    cen_rise_detect u_cen_rise_detect (
        .clk  (clk),
        .cen  (cen),
        .rise (cen_rise)
    );

    // Overrides are level-sensitive; an edge seen while one is active is simply lost.
    always_comb begin
        q_d = q_q;
        unique case (ovr_select(clr, set))
            OVR_CLR:  q_d = '0;
            OVR_SET:  q_d = '1;
            default:  if (cen_rise) q_d = din;
        endcase
    end

    always_ff @(posedge clk) begin
        q_q <= q_d;
    end

    assign q  = q_q;
    assign qn = ~q_q;

endmodule

// File: tb/tb_dff_pseudo_async_clr_pre.sv
// Directed bench for dff_pseudo_async_clr_pre at W=1 and W=4.
module tb_dff_pseudo_async_clr_pre;

    logic       clk = 1'b0;
    logic       clr1 = 0, set1 = 0, cen1 = 0;
    logic [0:0] din1 = '0;
    logic [0:0] q1, qn1;
    logic       clr4 = 0, set4 = 0, cen4 = 0;
    logic [3:0] din4 = '0;
    logic [3:0] q4, qn4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dff_pseudo_async_clr_pre #(.W(1)) dut1 (
        .clk(clk), .clr(clr1), .set(set1), .cen(cen1), .din(din1), .q(q1), .qn(qn1)
    );

    dff_pseudo_async_clr_pre #(.W(4)) dut4 (
        .clk(clk), .clr(clr4), .set(set4), .cen(cen4), .din(din4), .q(q4), .qn(qn4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string name, input logic exp_q);
        n_checks++;
        if (q1 !== exp_q || qn1 !== ~exp_q) begin
            n_fail++;
            $display("FAIL %s: q=%b qn=%b, expected q=%b qn=%b", name, q1, qn1, exp_q, ~exp_q);
        end
    endtask

    task automatic test_reset();
        #1;
        chk1("powerup_q1", 1'b0);
        n_checks++;
        if (q4 !== 4'h0 || qn4 !== 4'hF) begin
            n_fail++;
            $display("FAIL powerup_q4: q=%h qn=%h, expected q=0 qn=f", q4, qn4);
        end
        step();
        chk1("idle_hold", 1'b0);
    endtask

    task automatic test_capture();
        din1 = 1; cen1 = 1;
        step();
        chk1("capture_first", 1'b1);
        for (int i = 0; i < 4; i++) begin
            din1 = ~din1;
            step();
            chk1($sformatf("hold_no_recapture_%0d", i), 1'b1);
        end
    endtask

    task automatic test_falling();
        cen1 = 0; din1 = 0;
        step();
        chk1("falling_no_capture", 1'b1);
        step();
        chk1("low_hold", 1'b1);
        cen1 = 1;
        step();
        chk1("capture_zero", 1'b0);
    endtask

    task automatic test_set();
        cen1 = 0;
        step();
        chk1("pre_set_low", 1'b0);
        set1 = 1;
        step();
        chk1("set_first_edge", 1'b1);
        cen1 = 1; din1 = 0;
        step();
        chk1("set_ignores_rise", 1'b1);
        step();
        chk1("set_third", 1'b1);
        set1 = 0;
        step();
        chk1("set_release_consumed", 1'b1);
    endtask

    task automatic test_set_clr();
        set1 = 1; clr1 = 1;
        step();
        chk1("clr_over_set", 1'b0);
        clr1 = 0;
        step();
        chk1("set_after_clr_drop", 1'b1);
        set1 = 0;
        step();
        chk1("after_set_release", 1'b1);
    endtask

    task automatic test_clr_consume();
        cen1 = 0;
        step();
        clr1 = 1;
        step();
        chk1("clr_forces_zero", 1'b0);
        cen1 = 1; din1 = 1;
        step();
        chk1("clr_ignores_rise", 1'b0);
        clr1 = 0;
        step();
        chk1("clr_release_consumed", 1'b0);
    endtask

    task automatic test_release_edge();
        cen1 = 0; clr1 = 1;
        step();
        chk1("clr_before_release", 1'b0);
        clr1 = 0; cen1 = 1; din1 = 1;
        step();
        chk1("release_same_edge", 1'b1);
    endtask

    task automatic test_wide();
        din4 = 4'hA; cen4 = 1;
        step();
        n_checks++;
        if (q4 !== 4'hA || qn4 !== 4'h5) begin
            n_fail++;
            $display("FAIL wide_capture: q=%h qn=%h, expected q=a qn=5", q4, qn4);
        end
        clr4 = 1;
        step();
        n_checks++;
        if (q4 !== 4'h0 || qn4 !== 4'hF) begin
            n_fail++;
            $display("FAIL wide_clr: q=%h qn=%h, expected q=0 qn=f", q4, qn4);
        end
        clr4 = 0; set4 = 1;
        step();
        n_checks++;
        if (q4 !== 4'hF || qn4 !== 4'h0) begin
            n_fail++;
            $display("FAIL wide_set: q=%h qn=%h, expected q=f qn=0", q4, qn4);
        end
    endtask

    initial begin
        test_reset();
        test_capture();
        test_falling();
        test_set();
        test_set_clr();
        test_clr_consume();
        test_release_edge();
        test_wide();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
